fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives a word address to the synchronous instruction memory, which has 1-cycle read latency and no enable.
- Pairs each returned word with its PC and delivers {pc, instr, fault} to decode over a valid/ready handshake.
- Handles stalls without losing data, and handles redirects from branch/jump resolution.

Parameters:
- MEM_SIZE, 1024: number of instruction words; addresses >= MEM_SIZE are out of range.
- RESET_PC, 32'h0000_0000: word address fetched first after reset.
- QDEPTH, 2: output queue depth. Fixed at 2; the minimum for full throughput across the 1-cycle latency.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permit issuing new fetches; the queue still drains when low.
- imem_addr  out  32  word address to memory, driven directly from the pc register.
- imem_data  in  32  memory read data for the address presented in the previous cycle.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new word address.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts the head.
- out_pc  out  32  word address of the head instruction.
- out_instr  out  32  head instruction word.
- out_fault  out  1  head came from an out-of-range address.
- halted  out  1  unit is in the FAULT state.

Behaviour:
- Reset: the reset is asynchronous, active-low, and may occur at any time including mid-operation. While asserted:
  - pc = RESET_PC
  - inflight_valid = 0
  - queue empty: out_valid = 0, out_pc = 0, out_instr = 0, out_fault = 0
  - state = RUN, halted = 0
- Addressing: the pc is a word address and increments by 1 per issued fetch. Wrap at 32 bits is unreachable in practice, because FAULT triggers first.
- Issue: issue = (state==RUN) && fetch_en && !redirect_valid && (count + inflight_valid - deq) < 2, where deq = out_valid && out_ready. On issue:
  - inflight_valid <= 1
  - inflight_pc <= pc
  - pc <= pc+1
  - Otherwise inflight_valid <= 0 and pc holds.
- Return: when inflight_valid=1, the queue enqueues {inflight_pc, imem_data, inflight_pc >= MEM_SIZE} at the clock edge. The credit rule guarantees the queue is never full at enqueue; bench assertion: no overflow.
- Latency: an issue in cycle t gives out_valid in cycle t+2. First out_valid after reset release is in cycle 2, with out_pc = RESET_PC.
- Throughput: with out_ready held high, one instruction per cycle and consecutive out_pc values.
- Stall: with out_ready low, at most 2 words are held. Issue stops and imem_addr is stable. Outputs are stable while out_valid && !out_ready.
- Dequeue and enqueue in the same cycle are both honoured; count stays the same.
- Fault:
  - When an out-of-range pc is issued, state goes RUN -> FAULT in the same edge, and halted = 1 from the next cycle.
  - No further issues occur.
  - The faulting entry still reaches the output with out_fault = 1 and out_instr equal to the memory's default word, 32'hDEADBEEF.
  - Only a redirect or reset leaves FAULT.
- Redirect: has priority over everything else. At the edge:
  - queue cleared and inflight_valid <= 0, so data returning next cycle is dropped
  - pc <= redirect_pc
  - state <= RUN
  - A beat with out_valid && out_ready in the redirect cycle counts as delivered.
  - out_valid = 0 in the next cycle. The first redirected instruction appears 3 cycles after the redirect cycle.
  - Back-to-back redirects: the last one wins.
- fetch_en low: issue stops, in-flight data still lands in the queue, and the queue drains normally.

Decomposition:
- Package fetch_pkg holds:
  - DEFAULT_INSTR = 32'hDEADBEEF
  - fetch_state_t {RUN, FAULT}
  - fetch_entry_t {pc[31:0], instr[31:0], fault}
- Sub-module fetch_queue: 2-entry FIFO of fetch_entry_t with synchronous flush and count output. It is asynchronously cleared by rst_n.

Test Plan:
- Reset release with out_ready=1 and memory preloaded mem[k]=k+32'h1000 -> out_valid rises in cycle 2; beats give (pc, instr) = (0, 0x1000), (1, 0x1001), (2, 0x1002)… one per cycle.
- Hold out_ready=0 for 5 cycles from the beat at pc 3 -> pc 3 held stable, imem_addr frozen at 5. On release: pc 3, 4, 5 in order with no gap, no loss and no duplicate.
- redirect_valid with redirect_pc=100 in the same cycle as an accepted beat at pc 7 -> next beats come from pc 100, 101. No pc 8 or 9 is ever emitted.
- Redirect to MEM_SIZE-2 -> beats at pc 1022 and 1023 with out_fault=0, then pc 1024 with out_fault=1 and instr 0xDEADBEEF. halted=1 and no more beats. A redirect to 0 resumes fetch from pc 0.
- fetch_en toggled 1-0-1 with out_ready=1 -> at most 1 extra beat after fetch_en falls. Resumes from the next sequential pc.
- rst_n asserted mid-stream with the queue full -> out_valid=0 and pc=RESET_PC immediately, before the next clock edge. Normal restart follows release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its output queue.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_INSTR = 32'hDEADBEEF;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  function automatic logic out_of_range(input logic [31:0] addr, input logic [31:0] limit);
    return addr >= limit;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory read bus, redirect request and decode handshake seen by the fetch unit.
interface fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output out_fault
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  out_fault
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched words; flush empties it synchronously, rst_n clears it asynchronously.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         enq,
  input  fetch_entry_t enq_entry,
  input  logic         deq,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t slots [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_enq;
  logic         do_deq;

  assign head_valid = (count != 2'd0);
  assign do_deq     = deq && head_valid;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign do_enq     = enq && ((count != 2'd2) || do_deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots[0] <= '0;
      slots[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_enq) begin
        slots[wr_ptr] <= enq_entry;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_deq) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_enq) - 2'(do_deq);
    end
  end

  always_comb begin
    head = '0;
    if (head_valid) begin
      head = slots[rd_ptr];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the pc, reads a 1-cycle-latency memory and queues {pc, instr, fault} for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     fetch_en,
  fetch_if.master  bus,
  output logic     halted
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_SIZE);
  localparam logic [2:0]  CREDITS   = 3'(QDEPTH);

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0]  pc;
  logic [31:0]  inflight_pc;
  logic         inflight_valid;
  logic         issue;
  logic         deq;
  logic [2:0]   occupancy;
  logic         inflight_fault;

  fetch_entry_t enq_entry;
  fetch_entry_t head;
  logic         head_valid;
  logic [1:0]   q_count;

  assign deq = head_valid && bus.out_ready;

  // Queued words plus the word still in the memory pipe must fit, or a stall would drop data.
  assign occupancy = {1'b0, q_count} + {2'b00, inflight_valid} - {2'b00, deq};
  assign issue     = (state == RUN) && fetch_en && !bus.redirect_valid && (occupancy < CREDITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    halted     = (state == FAULT);
    if (bus.redirect_valid) begin
      state_next = RUN;
    end else if (issue && out_of_range(pc, MEM_LIMIT)) begin
      state_next = FAULT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc             <= bus.redirect_pc;
      inflight_valid <= 1'b0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd1;
      end
    end
  end

  assign inflight_fault = out_of_range(inflight_pc, MEM_LIMIT);

  always_comb begin
    enq_entry.pc    = inflight_pc;
    enq_entry.instr = inflight_fault ? DEFAULT_INSTR : bus.imem_data;
    enq_entry.fault = inflight_fault;
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (bus.redirect_valid),
    .enq        (inflight_valid),
    .enq_entry  (enq_entry),
    .deq        (deq),
    .head       (head),
    .head_valid (head_valid),
    .count      (q_count)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.out_fault = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit against a preloaded synchronous memory model.
module tb_fetch_unit;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        flt;
    logic [31:0] addr;
    logic        halt;
  } row_t;

  logic clk;
  logic rst_n;
  logic fetch_en;
  logic halted;
  int   checks;
  int   passes;

  logic [31:0] mem [1024];
  row_t        tbl [39];

  fetch_if bus ();

  fetch_unit #(
    .MEM_SIZE (1024),
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fetch_en (fetch_en),
    .bus      (bus),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory, one cycle of latency, default word outside the array.
  always @(posedge clk) begin
    bus.imem_data <= (bus.imem_addr < 32'd1024) ? mem[bus.imem_addr[9:0]] : 32'hDEADBEEF;
  end

  // An in-flight word arriving at a full, non-draining, non-flushed queue would be lost.
  always @(negedge clk) begin
    if (rst_n && !bus.redirect_valid && dut.inflight_valid && dut.q_count == 2'd2 &&
        !(bus.out_valid && bus.out_ready)) begin
      checks = checks + 1;
      $display("[TB] FAIL overflow: queue full with word in flight at %0t", $time);
    end
  end

  function automatic row_t mk(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic flt,
                              input logic [31:0] addr, input logic halt);
    row_t r;
    r.en    = en;
    r.rdy   = rdy;
    r.rv    = rv;
    r.rpc   = rpc;
    r.v     = v;
    r.pc    = pc;
    r.flt   = flt;
    r.instr = flt ? 32'hDEADBEEF : pc + 32'h1000;
    r.addr  = addr;
    r.halt  = halt;
    return r;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act === exp) begin
      passes = passes + 1;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input row_t r);
    fetch_en           = r.en;
    bus.out_ready      = r.rdy;
    bus.redirect_valid = r.rv;
    bus.redirect_pc    = r.rpc;
  endtask

  task automatic check_output(input row_t r, input string tag);
    check_val($sformatf("%s valid", tag), {31'd0, bus.out_valid}, {31'd0, r.v});
    if (r.v) begin
      check_val($sformatf("%s pc", tag), bus.out_pc, r.pc);
      check_val($sformatf("%s instr", tag), bus.out_instr, r.instr);
      check_val($sformatf("%s fault", tag), {31'd0, bus.out_fault}, {31'd0, r.flt});
    end
    check_val($sformatf("%s addr", tag), bus.imem_addr, r.addr);
    check_val($sformatf("%s halted", tag), {31'd0, halted}, {31'd0, r.halt});
  endtask

  task automatic check_reset(input string tag);
    check_val($sformatf("%s valid", tag), {31'd0, bus.out_valid}, 32'd0);
    check_val($sformatf("%s pc", tag), bus.out_pc, 32'd0);
    check_val($sformatf("%s instr", tag), bus.out_instr, 32'd0);
    check_val($sformatf("%s fault", tag), {31'd0, bus.out_fault}, 32'd0);
    check_val($sformatf("%s addr", tag), bus.imem_addr, 32'd0);
    check_val($sformatf("%s halted", tag), {31'd0, halted}, 32'd0);
  endtask

  task automatic run_row(input row_t r, input logic release_reset, input string tag);
    @(posedge clk);
    #1;
    if (release_reset) rst_n = 1'b1;
    apply_stimulus(r);
    @(negedge clk);
    check_output(r, tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    passes = 0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'(k) + 32'h1000;

    //            en rdy rv rpc    v  pc    flt addr   halt
    tbl[0]  = mk(1, 1, 0, 0,     0, 0,    0,  0,     0);
    tbl[1]  = mk(1, 1, 0, 0,     0, 0,    0,  1,     0);
    tbl[2]  = mk(1, 1, 0, 0,     1, 0,    0,  2,     0);
    tbl[3]  = mk(1, 1, 0, 0,     1, 1,    0,  3,     0);
    tbl[4]  = mk(1, 1, 0, 0,     1, 2,    0,  4,     0);
    tbl[5]  = mk(1, 0, 0, 0,     1, 3,    0,  5,     0);
    tbl[6]  = mk(1, 0, 0, 0,     1, 3,    0,  5,     0);
    tbl[7]  = mk(1, 0, 0, 0,     1, 3,    0,  5,     0);
    tbl[8]  = mk(1, 0, 0, 0,     1, 3,    0,  5,     0);
    tbl[9]  = mk(1, 0, 0, 0,     1, 3,    0,  5,     0);
    tbl[10] = mk(1, 1, 0, 0,     1, 3,    0,  5,     0);
    tbl[11] = mk(1, 1, 0, 0,     1, 4,    0,  6,     0);
    tbl[12] = mk(1, 1, 0, 0,     1, 5,    0,  7,     0);
    tbl[13] = mk(1, 1, 0, 0,     1, 6,    0,  8,     0);
    tbl[14] = mk(1, 1, 1, 100,   1, 7,    0,  9,     0);
    tbl[15] = mk(1, 1, 0, 0,     0, 0,    0,  100,   0);
    tbl[16] = mk(1, 1, 0, 0,     0, 0,    0,  101,   0);
    tbl[17] = mk(1, 1, 0, 0,     1, 100,  0,  102,   0);
    tbl[18] = mk(1, 1, 0, 0,     1, 101,  0,  103,   0);
    tbl[19] = mk(0, 1, 0, 0,     1, 102,  0,  104,   0);
    tbl[20] = mk(0, 1, 0, 0,     1, 103,  0,  104,   0);
    tbl[21] = mk(0, 1, 0, 0,     0, 0,    0,  104,   0);
    tbl[22] = mk(1, 1, 0, 0,     0, 0,    0,  104,   0);
    tbl[23] = mk(1, 1, 0, 0,     0, 0,    0,  105,   0);
    tbl[24] = mk(1, 1, 0, 0,     1, 104,  0,  106,   0);
    tbl[25] = mk(1, 1, 0, 0,     1, 105,  0,  107,   0);
    tbl[26] = mk(1, 1, 1, 1022,  1, 106,  0,  108,   0);
    tbl[27] = mk(1, 1, 0, 0,     0, 0,    0,  1022,  0);
    tbl[28] = mk(1, 1, 0, 0,     0, 0,    0,  1023,  0);
    tbl[29] = mk(1, 1, 0, 0,     1, 1022, 0,  1024,  0);
    tbl[30] = mk(1, 1, 0, 0,     1, 1023, 0,  1025,  1);
    tbl[31] = mk(1, 1, 0, 0,     1, 1024, 1,  1025,  1);
    tbl[32] = mk(1, 1, 0, 0,     0, 0,    0,  1025,  1);
    tbl[33] = mk(1, 1, 0, 0,     0, 0,    0,  1025,  1);
    tbl[34] = mk(1, 1, 1, 0,     0, 0,    0,  1025,  1);
    tbl[35] = mk(1, 1, 0, 0,     0, 0,    0,  0,     0);
    tbl[36] = mk(1, 1, 0, 0,     0, 0,    0,  1,     0);
    tbl[37] = mk(1, 1, 0, 0,     1, 0,    0,  2,     0);
    tbl[38] = mk(1, 1, 0, 0,     1, 1,    0,  3,     0);

    rst_n              = 1'b0;
    fetch_en           = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");

    for (int i = 0; i < 39; i++) begin
      run_row(tbl[i], (i == 0), $sformatf("row%0d", i));
    end

    // Fill the queue with decode stalled, then pull reset between clock edges.
    run_row(mk(1, 0, 0, 0, 1, 2, 0, 4, 0), 1'b0, "fill1");
    run_row(mk(1, 0, 0, 0, 1, 2, 0, 4, 0), 1'b0, "fill2");
    #1 rst_n = 1'b0;
    #1 check_reset("async reset");
    run_row(mk(1, 1, 0, 0,   0, 0,   0, 0,   0), 1'b1, "restart0");
    run_row(mk(1, 1, 0, 0,   0, 0,   0, 1,   0), 1'b0, "restart1");
    run_row(mk(1, 1, 0, 0,   1, 0,   0, 2,   0), 1'b0, "restart2");

    // Back-to-back redirects: only the second target is fetched.
    run_row(mk(1, 1, 1, 50,  1, 1,   0, 3,   0), 1'b0, "redir_a");
    run_row(mk(1, 1, 1, 200, 0, 0,   0, 50,  0), 1'b0, "redir_b");
    run_row(mk(1, 1, 0, 0,   0, 0,   0, 200, 0), 1'b0, "redir_c");
    run_row(mk(1, 1, 0, 0,   0, 0,   0, 201, 0), 1'b0, "redir_d");
    run_row(mk(1, 1, 0, 0,   1, 200, 0, 202, 0), 1'b0, "redir_e");
    run_row(mk(1, 1, 0, 0,   1, 201, 0, 203, 0), 1'b0, "redir_f");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
